// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC/fetch stage with prefetch FIFO feeding decode
module instruction_fetch_unit #(
  parameter int                 ADDR_W     = 64,
  parameter int                 INSTR_W    = 64,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter int                 PC_STEP    = 8,
  parameter int                 FIFO_DEPTH = 2,
  parameter logic [INSTR_W-1:0] HALT_INSTR = INSTR_W'(64'h95)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  input  logic               dec_ready,
  output logic               busy,
  output logic               halted
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HALTED} state_t;

  state_t               state_q;
  logic [ADDR_W-1:0]    pc_q;
  logic [INSTR_W-1:0]   fifo_instr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]    fifo_pc_q    [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]     count_q;

  logic pop, full, can_push, end_word, fetch_ok, push, redirect_act;

  always_comb begin
    full         = (count_q == CNT_W'(FIFO_DEPTH));
    pop          = dec_valid && dec_ready;
    can_push     = !full || pop;
    end_word     = (imem_rdata == HALT_INSTR) || (imem_rdata == '0);
    redirect_act = redirect && (state_q == S_FETCH || state_q == S_DRAIN);
    fetch_ok     = (state_q == S_FETCH) && can_push && !redirect_act;
    push         = fetch_ok && !end_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
    end else if (redirect_act) begin
      // Flush wins over any same-cycle push, pop or end-of-program detection.
      state_q  <= S_FETCH;
      pc_q     <= {redirect_pc[ADDR_W-1:3], 3'b000};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_instr_q[wr_ptr_q] <= imem_rdata;
        fifo_pc_q[wr_ptr_q]    <= pc_q;
        wr_ptr_q               <= wr_ptr_q + PTR_W'(1);
        pc_q                   <= pc_q + ADDR_W'(PC_STEP);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (fetch_ok && end_word) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (count_q == '0) state_q <= S_HALTED;
        end
        S_HALTED: begin
          if (start) begin
            pc_q    <= RESET_PC;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign dec_valid = (count_q != '0);
  assign dec_instr = dec_valid ? fifo_instr_q[rd_ptr_q] : '0;
  assign dec_pc    = dec_valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign halted    = (state_q == S_HALTED);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] imem_addr;
  logic [63:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        dec_valid;
  logic [63:0] dec_instr;
  logic [63:0] dec_pc;
  logic        dec_ready;
  logic        busy;
  logic        halted;

  logic [63:0] mem [16];
  logic [63:0] num_words;
  logic [63:0] word_idx;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] W_A = 64'h1111_0000_AAAA_0001;
  localparam logic [63:0] W_B = 64'h2222_0000_BBBB_0002;
  localparam logic [63:0] W_C = 64'h3333_0000_CCCC_0003;

  instruction_fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .dec_valid  (dec_valid),
    .dec_instr  (dec_instr),
    .dec_pc     (dec_pc),
    .dec_ready  (dec_ready),
    .busy       (busy),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Words at or beyond num_words read as 0, like an out-of-range memory access.
  assign word_idx   = imem_addr >> 3;
  assign imem_rdata = (word_idx < num_words) ? mem[word_idx[3:0]] : 64'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    dec_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_abc(input logic [63:0] n);
    for (int i = 0; i < 16; i++) mem[i] = 64'h95;
    mem[0] = W_A;
    mem[1] = W_B;
    mem[2] = W_C;
    num_words = n;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [63:0] instr, input logic [63:0] pc);
    check({tag, "_valid"}, 64'(dec_valid), 64'd1);
    check({tag, "_instr"}, dec_instr, instr);
    check({tag, "_pc"}, dec_pc, pc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    load_abc(64'd16);
    do_reset();

    // 1: reset state, then straight-line program with decoder always ready
    check("rst_valid", 64'(dec_valid), 64'd0);
    check("rst_instr", dec_instr, 64'd0);
    check("rst_pc", dec_pc, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_addr", imem_addr, 64'd0);
    dec_ready = 1'b1;
    pulse_start();
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_first_empty", 64'(dec_valid), 64'd0);
    tick(); check_head("t1_a", W_A, 64'd0);
    tick(); check_head("t1_b", W_B, 64'd8);
    tick(); check_head("t1_c", W_C, 64'd16);
    check("t1_addr_end", imem_addr, 64'd24);
    tick();
    check("t1_drain_valid", 64'(dec_valid), 64'd0);
    check("t1_drain_busy", 64'(busy), 64'd1);
    tick();
    check("t1_halted", 64'(halted), 64'd1);
    check("t1_not_busy", 64'(busy), 64'd0);
    tick();
    check("t1_halt_hold", 64'(halted), 64'd1);
    check("t1_no_95", 64'(dec_valid), 64'd0);

    // 2 and 4: backpressure fills FIFO, then simultaneous push+pop on full FIFO
    do_reset();
    pulse_start();
    tick();
    tick();
    check_head("t2_full", W_A, 64'd0);
    check("t2_addr_stall", imem_addr, 64'd16);
    tick();
    check_head("t2_hold", W_A, 64'd0);
    check("t2_addr_hold", imem_addr, 64'd16);
    dec_ready = 1'b1;
    tick();
    check_head("t4_pushpop", W_B, 64'd8);
    check("t4_addr", imem_addr, 64'd24);
    dec_ready = 1'b0;
    tick();
    check_head("t4_still_b", W_B, 64'd8);
    check("t4_stall_busy", 64'(busy), 64'd1);
    dec_ready = 1'b1;
    tick(); check_head("t4_c", W_C, 64'd16);
    tick(); check("t4_empty", 64'(dec_valid), 64'd0);
    tick(); check("t4_halted", 64'(halted), 64'd1);

    // 3: redirect ignored in IDLE, then flush of a full FIFO
    for (int i = 0; i < 16; i++) mem[i] = (i < 8) ? 64'h1000 + 64'(i) : 64'h95;
    num_words = 64'd16;
    do_reset();
    redirect = 1'b1;
    redirect_pc = 64'h40;
    tick();
    redirect = 1'b0;
    check("t3_idle_busy", 64'(busy), 64'd0);
    check("t3_idle_addr", imem_addr, 64'd0);
    pulse_start();
    tick();
    tick();
    check_head("t3_full", 64'h1000, 64'd0);
    redirect = 1'b1;
    redirect_pc = 64'h2B;
    tick();
    redirect = 1'b0;
    check("t3_flush_valid", 64'(dec_valid), 64'd0);
    check("t3_flush_instr", dec_instr, 64'd0);
    check("t3_new_pc", imem_addr, 64'h28);
    tick();
    check_head("t3_w5", 64'h1005, 64'h28);
    redirect = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect = 1'b0;
    check("t3_align_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    check("t3_top_valid", 64'(dec_valid), 64'd0);
    tick();
    check("t3_top_drain", 64'(busy), 64'd1);
    tick();
    check("t3_top_halted", 64'(halted), 64'd1);

    // 5: asynchronous reset between clock edges
    load_abc(64'd16);
    do_reset();
    dec_ready = 1'b1;
    pulse_start();
    tick();
    tick();
    #3;
    reset = 1'b1;
    #1;
    check("t5_valid", 64'(dec_valid), 64'd0);
    check("t5_instr", dec_instr, 64'd0);
    check("t5_addr", imem_addr, 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    #1;
    reset = 1'b0;
    tick();
    check("t5_idle", 64'(busy), 64'd0);
    pulse_start();
    tick();
    check_head("t5_restart", W_A, 64'd0);

    // 6: out-of-range read returns 0 -> halt, then restart from HALTED
    load_abc(64'd3);
    do_reset();
    dec_ready = 1'b1;
    pulse_start();
    tick(); check_head("t6_a", W_A, 64'd0);
    tick(); check_head("t6_b", W_B, 64'd8);
    tick(); check_head("t6_c", W_C, 64'd16);
    tick(); check("t6_drain", 64'(busy), 64'd1);
    tick(); check("t6_halted", 64'(halted), 64'd1);
    check("t6_halt_addr", imem_addr, 64'd24);
    pulse_start();
    check("t6_rs_busy", 64'(busy), 64'd1);
    check("t6_rs_halted", 64'(halted), 64'd0);
    check("t6_rs_addr", imem_addr, 64'd0);
    tick();
    check_head("t6_rs_a", W_A, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
